// File: rtl/rr_arbiter8.sv
// rr_arbiter8 - eight-way round-robin arbiter for a shared one-hot resource.
//
// A winner is picked from the request vector by scanning upward from a
// rotating pointer. The grant is held until the winner drops its request or
// until it has held the resource for MAX_HOLD cycles. Every release is
// followed by at least one idle cycle (break-before-make).
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         arbitration enable; gates new grants only
//   req[7:0]   level-sensitive request vector, bit i = requester i
//   gnt[7:0]   one-hot grant, decode of gnt_id, zero when idle
//   gnt_id     binary index of the current (or last) grantee
//   gnt_valid  high while a grant is active
//   timeout    one-cycle pulse after a grant is preempted by MAX_HOLD
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = $clog2(MAX_HOLD) + 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [2:0]       pick;
  logic             pick_found;
  logic [2:0]       scan_idx;

  // Scan ptr, ptr+1, ... ptr+7 (mod 8). Walking the offsets from far to near
  // lets the nearest set request overwrite any farther one, so the result is
  // the first hit in round-robin order.
  always_comb begin
    pick       = 3'd0;
    pick_found = 1'b0;
    scan_idx   = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      scan_idx = ptr + 3'(k);
      if (req[scan_idx]) begin
        pick       = scan_idx;
        pick_found = 1'b1;
      end
    end
  end

  // Arbitration state machine. All outputs are registered here; release
  // advances the pointer past the previous winner so it gets lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 3'd0;
      hold_cnt  <= '0;
      gnt       <= 8'd0;
      gnt_id    <= 3'd0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (en && pick_found) begin
            gnt_id    <= pick;
            gnt       <= 8'b1 << pick;
            gnt_valid <= 1'b1;
            hold_cnt  <= CNT_W'(1);
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!req[gnt_id] || (hold_cnt == CNT_W'(MAX_HOLD))) begin
            // Preemption is only flagged when the holder still wants the bus.
            timeout   <= req[gnt_id];
            gnt       <= 8'd0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
            ptr       <= gnt_id + 3'd1;
            state     <= IDLE;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8 - scoreboard bench for rr_arbiter8.
//
// Three arbiters with MAX_HOLD = 4, 2 and 1 share one stimulus stream. The
// driver feeds inputs on the falling edge, steps a behavioural model for each
// instance and pushes the expected outputs; a monitor pops one entry per
// rising edge and compares all three instances.
module tb_rr_arbiter8;

  localparam int NI = 3;
  localparam int HOLD [NI] = '{4, 2, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] req;

  logic [7:0] gnt       [NI];
  logic [2:0] gnt_id    [NI];
  logic       gnt_valid [NI];
  logic       timeout   [NI];

  typedef struct packed {
    logic [NI-1:0][7:0] gnt;
    logic [NI-1:0][2:0] id;
    logic [NI-1:0]      v;
    logic [NI-1:0]      to;
  } exp_t;

  exp_t sbq[$];
  int   errors  = 0;
  int   checks  = 0;
  bit   running = 1'b0;

  // behavioural model state, one set per instance
  bit m_busy  [NI];
  int m_owner [NI];
  int m_held  [NI];
  int m_ptr   [NI];
  bit m_to    [NI];

  always #5 clk = ~clk;

  rr_arbiter8 #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt[0]), .gnt_id(gnt_id[0]), .gnt_valid(gnt_valid[0]), .timeout(timeout[0])
  );

  rr_arbiter8 #(.MAX_HOLD(2)) u_h2 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt[1]), .gnt_id(gnt_id[1]), .gnt_valid(gnt_valid[1]), .timeout(timeout[1])
  );

  rr_arbiter8 #(.MAX_HOLD(1)) u_h1 (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt[2]), .gnt_id(gnt_id[2]), .gnt_valid(gnt_valid[2]), .timeout(timeout[2])
  );

  task automatic checkOutput(input string name, input int idx,
                             input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s (MAX_HOLD=%0d) at %0t: actual=%h expected=%h",
               name, HOLD[idx], $time, act, exp);
    end
  endtask

  // One clock edge of the arbiter rules: who holds the resource, for how long,
  // and where the next round-robin scan begins.
  task automatic modelStep(input logic r, input logic e, input logic [7:0] rq,
                           output exp_t x);
    int c;
    int found;
    x = '0;
    for (int i = 0; i < NI; i++) begin
      if (r) begin
        m_busy[i] = 1'b0; m_owner[i] = 0; m_held[i] = 0; m_ptr[i] = 0; m_to[i] = 1'b0;
      end else if (!m_busy[i]) begin
        m_to[i] = 1'b0;
        if (e && rq != 8'd0) begin
          found = -1;
          for (int k = 0; k < 8; k++) begin
            c = (m_ptr[i] + k) % 8;
            if (found < 0 && rq[c]) found = c;
          end
          m_owner[i] = found;
          m_busy[i]  = 1'b1;
          m_held[i]  = 1;
        end
      end else if (!rq[m_owner[i]]) begin
        m_busy[i] = 1'b0; m_ptr[i] = (m_owner[i] + 1) % 8; m_to[i] = 1'b0;
      end else if (m_held[i] == HOLD[i]) begin
        m_busy[i] = 1'b0; m_ptr[i] = (m_owner[i] + 1) % 8; m_to[i] = 1'b1;
      end else begin
        m_held[i] = m_held[i] + 1;
        m_to[i]   = 1'b0;
      end
      x.gnt[i] = m_busy[i] ? 8'(1 << m_owner[i]) : 8'd0;
      x.id[i]  = 3'(m_owner[i]);
      x.v[i]   = m_busy[i];
      x.to[i]  = m_to[i];
    end
  endtask

  task automatic applyStimulus(input logic r, input logic e, input logic [7:0] rq,
                               input int n);
    exp_t x;
    repeat (n) begin
      @(negedge clk);
      rst = r; en = e; req = rq;
      modelStep(r, e, rq, x);
      sbq.push_back(x);
      running = 1'b1;
    end
  endtask

  // Assert reset between edges and check that outputs clear before the next edge.
  task automatic midReset(input logic e, input logic [7:0] rq);
    exp_t x;
    @(negedge clk);
    en = e; req = rq;
    #2 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput("async_rst_gnt", i, gnt[i], 8'd0);
      checkOutput("async_rst_valid", i, {7'd0, gnt_valid[i]}, 8'd0);
      checkOutput("async_rst_timeout", i, {7'd0, timeout[i]}, 8'd0);
    end
    modelStep(1'b1, e, rq, x);
    sbq.push_back(x);
  endtask

  // Monitor: one expected entry per rising edge, sampled 2 time units later.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #2;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        for (int i = 0; i < NI; i++) begin
          checkOutput("gnt", i, gnt[i], x.gnt[i]);
          checkOutput("gnt_valid", i, {7'd0, gnt_valid[i]}, {7'd0, x.v[i]});
          checkOutput("timeout", i, {7'd0, timeout[i]}, {7'd0, x.to[i]});
          if (x.v[i]) checkOutput("gnt_id", i, {5'd0, gnt_id[i]}, {5'd0, x.id[i]});
          checkOutput("onehot", i, ($countones(gnt[i]) <= 1) ? 8'd1 : 8'd0, 8'd1);
        end
      end else if (running) begin
        checks++;
        errors++;
        $display("[TB] FAIL scoreboard_empty at %0t: actual=0 entries expected=1", $time);
      end
    end
  end

  initial begin : driver
    logic [31:0] rv;
    logic [7:0]  rq;
    rst = 1'b0; en = 1'b0; req = 8'd0;
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      checkOutput("reset_gnt", i, gnt[i], 8'd0);
      checkOutput("reset_gnt_id", i, {5'd0, gnt_id[i]}, 8'd0);
      checkOutput("reset_valid", i, {7'd0, gnt_valid[i]}, 8'd0);
      checkOutput("reset_timeout", i, {7'd0, timeout[i]}, 8'd0);
    end
    applyStimulus(1'b1, 1'b0, 8'd0, 1);

    // reset in the middle of a grant, then a fresh grant from requester 0
    applyStimulus(1'b0, 1'b1, 8'h08, 3);
    midReset(1'b1, 8'h08);
    applyStimulus(1'b0, 1'b1, 8'h01, 3);
    applyStimulus(1'b0, 1'b1, 8'h00, 2);

    // voluntary release after three cycles
    applyStimulus(1'b0, 1'b1, 8'h20, 3);
    applyStimulus(1'b0, 1'b1, 8'h00, 2);

    // pointer wrap: 6 then 7 wins over 0, then 0
    applyStimulus(1'b0, 1'b1, 8'h40, 2);
    applyStimulus(1'b0, 1'b1, 8'h00, 2);
    applyStimulus(1'b0, 1'b1, 8'h81, 2);
    applyStimulus(1'b0, 1'b1, 8'h01, 3);
    applyStimulus(1'b0, 1'b1, 8'h00, 2);

    // enable gating, including en dropping during a grant
    applyStimulus(1'b0, 1'b0, 8'h10, 3);
    applyStimulus(1'b0, 1'b1, 8'h10, 2);
    applyStimulus(1'b0, 1'b0, 8'h10, 6);
    applyStimulus(1'b0, 1'b0, 8'h00, 2);

    // full rotation with every requester active
    midReset(1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'hFF, 44);
    applyStimulus(1'b0, 1'b1, 8'h00, 2);

    // sole persistent requester
    applyStimulus(1'b0, 1'b1, 8'h04, 9);
    applyStimulus(1'b0, 1'b1, 8'h00, 2);

    // randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 400; n++) begin
      rv = $urandom();
      case (rv[17:16])
        2'd0:    rq = 8'd0;
        2'd1:    rq = 8'b1 << rv[2:0];
        2'd2:    rq = rv[7:0] & rv[15:8];
        default: rq = rv[7:0];
      endcase
      if (rv[25:20] == 6'd0) midReset(rv[26], rq);
      else applyStimulus(1'b0, rv[29:27] != 3'd0, rq, 1);
    end

    @(posedge clk);
    #4;
    running = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
